eth_tx_frame_fifo: RTL and testbench

//  Store-and-forward AXI-Stream frame FIFO between the UDP frame generator and the
//  10G MAC TX port. It buffers whole frames and releases a frame to the MAC only

---
 rtl/eth_tx_frame_fifo_if.sv | 12 +
 rtl/eth_tx_frame_fifo.sv | 162 ++++++++++++++++
 tb/tb_eth_tx_frame_fifo.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_frame_fifo_if.sv
// AXI-Stream bundle shared by the generator side and the MAC side of the TX frame FIFO.
interface eth_tx_frame_fifo_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: whole frames are released to the MAC only after tlast.
// Optional ETH_TX_FIFO_STATS_EN adds frames_in / frames_out / frames_dropped counters.
//
//  state   | meaning
//  W_IDLE  | between frames, next beat is a first beat
//  W_FRAME | writing a frame that has not yet seen tlast
//  W_DROP  | discarding beats of a bad/overflowed frame until tlast
module eth_tx_frame_fifo #(
    parameter int ADDR_W = 9,
    parameter int FCNT_W = 6
) (
    input  logic                clk156,
    input  logic                reset,
    eth_tx_frame_fifo_if.slave  s_axis,
    eth_tx_frame_fifo_if.master m_axis_tx,
    output logic [FCNT_W-1:0]   frames_stored
`ifdef ETH_TX_FIFO_STATS_EN
    ,
    output logic [31:0]         frames_in,
    output logic [31:0]         frames_out,
    output logic [31:0]         frames_dropped
`endif
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   PTR_ONE  = 1;
    localparam logic [FCNT_W-1:0] FCNT_MAX = '1;
    localparam logic [FCNT_W-1:0] FCNT_ONE = 1;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FRAME = 2'd1,
        W_DROP  = 2'd2
    } w_state_t;

    w_state_t        w_state, w_state_nxt;
    logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
    logic [72:0]     mem [DEPTH];
    logic [72:0]     out_word;
    logic            out_valid;
    logic [31:0]     drop_cnt;

    logic wr_en, commit, rewind, drop_done;
    logic word_full, frame_full, out_hs, out_last_hs, rd_en;

    // rd_ptr only advances on an output handshake, so the prefetched beat still occupies its word
    assign word_full  = (wr_ptr[ADDR_W-1:0] + PTR_ONE[ADDR_W-1:0]) == rd_ptr[ADDR_W-1:0];
    assign frame_full = (frames_stored == FCNT_MAX);

    assign s_axis.tready = ~reset;

    always_comb begin
        w_state_nxt = w_state;
        wr_en       = 1'b0;
        commit      = 1'b0;
        rewind      = 1'b0;
        drop_done   = 1'b0;
        if (s_axis.tvalid) begin
            unique case (w_state)
                W_IDLE: begin
                    if (word_full || frame_full || s_axis.tuser) begin
                        if (s_axis.tlast) drop_done   = 1'b1;
                        else              w_state_nxt = W_DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (s_axis.tlast) commit      = 1'b1;
                        else              w_state_nxt = W_FRAME;
                    end
                end
                W_FRAME: begin
                    if (word_full || s_axis.tuser) begin
                        rewind = 1'b1;
                        if (s_axis.tlast) begin
                            drop_done   = 1'b1;
                            w_state_nxt = W_IDLE;
                        end else begin
                            w_state_nxt = W_DROP;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (s_axis.tlast) begin
                            commit      = 1'b1;
                            w_state_nxt = W_IDLE;
                        end
                    end
                end
                W_DROP: begin
                    if (s_axis.tlast) begin
                        drop_done   = 1'b1;
                        w_state_nxt = W_IDLE;
                    end
                end
                default: w_state_nxt = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            w_state    <= W_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            drop_cnt   <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (rewind)     wr_ptr <= commit_ptr;
            else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (commit)     commit_ptr <= wr_ptr + PTR_ONE;
            if (drop_done)  drop_cnt <= drop_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk156) begin
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end

    // Only committed words are fetched, so a frame streams out without gaps once started
    assign out_hs      = out_valid & m_axis_tx.tready;
    assign out_last_hs = out_hs & out_word[72];
    assign rd_en       = (~out_valid | m_axis_tx.tready) & (fetch_ptr != commit_ptr);

    always_ff @(posedge clk156) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_word      <= '0;
            fetch_ptr     <= '0;
            rd_ptr        <= '0;
            frames_stored <= '0;
        end else begin
            if (rd_en) begin
                out_word  <= mem[fetch_ptr[ADDR_W-1:0]];
                fetch_ptr <= fetch_ptr + PTR_ONE;
                out_valid <= 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (out_hs) rd_ptr <= rd_ptr + PTR_ONE;
            if (commit && !out_last_hs)      frames_stored <= frames_stored + FCNT_ONE;
            else if (!commit && out_last_hs) frames_stored <= frames_stored - FCNT_ONE;
        end
    end

    assign m_axis_tx.tvalid = out_valid;
    assign m_axis_tx.tdata  = out_word[63:0];
    assign m_axis_tx.tkeep  = out_word[71:64];
    assign m_axis_tx.tlast  = out_word[72];
    assign m_axis_tx.tuser  = 1'b0;

`ifdef ETH_TX_FIFO_STATS_EN
    always_ff @(posedge clk156) begin
        if (reset) begin
            frames_in  <= '0;
            frames_out <= '0;
        end else begin
            if (commit)      frames_in  <= frames_in + 32'd1;
            if (out_last_hs) frames_out <= frames_out + 32'd1;
        end
    end
    assign frames_dropped = drop_cnt;
`endif

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Bench for eth_tx_frame_fifo (small config: 16 words, 3 frames) against a frame-queue model.
module tb_eth_tx_frame_fifo;
    localparam int ADDR_W = 4;
    localparam int FCNT_W = 2;
    localparam int WORDS  = 1 << ADDR_W;
    localparam int FMAX   = (1 << FCNT_W) - 1;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          ccyc;
    } beat_t;

    logic clk156;
    logic reset;
    logic [FCNT_W-1:0] frames_stored;
`ifdef ETH_TX_FIFO_STATS_EN
    logic [31:0] frames_in, frames_out, frames_dropped;
`endif

    eth_tx_frame_fifo_if s_axis ();
    eth_tx_frame_fifo_if m_axis_tx ();

    eth_tx_frame_fifo #(.ADDR_W(ADDR_W), .FCNT_W(FCNT_W)) dut (
        .clk156        (clk156),
        .reset         (reset),
        .s_axis        (s_axis),
        .m_axis_tx     (m_axis_tx),
        .frames_stored (frames_stored)
`ifdef ETH_TX_FIFO_STATS_EN
        ,
        .frames_in      (frames_in),
        .frames_out     (frames_out),
        .frames_dropped (frames_dropped)
`endif
    );

    initial clk156 = 1'b0;
    always #5 clk156 = ~clk156;

    // reference model: committed beats awaiting output, plus the frame being written
    beat_t pend[$];
    beat_t part[$];
    int    nfr, cyc, m_in, m_out, m_drop;
    bit    dropping, after_rst, rand_rdy;
    int    tests, fails;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        part.delete();
        nfr = 0; dropping = 0; m_in = 0; m_out = 0; m_drop = 0;
    endtask

    task automatic model_edge(input bit hs);
        beat_t b;
        bit    do_commit, bad;
        int    used;
        do_commit = 0;
        after_rst = 0;
        if (reset) begin
            model_clear();
            after_rst = 1;
            cyc++;
            return;
        end
        if (s_axis.tvalid) begin
            if (dropping) begin
                if (s_axis.tlast) begin
                    dropping = 0;
                    m_drop++;
                end
            end else begin
                used = pend.size() + part.size();
                bad  = (used == WORDS - 1) || (part.size() == 0 && nfr == FMAX) || s_axis.tuser;
                if (bad) begin
                    part.delete();
                    if (s_axis.tlast) m_drop++;
                    else              dropping = 1;
                end else begin
                    b.data = s_axis.tdata;
                    b.keep = s_axis.tkeep;
                    b.last = s_axis.tlast;
                    b.ccyc = cyc;
                    part.push_back(b);
                    if (s_axis.tlast) do_commit = 1;
                end
            end
        end
        if (hs) begin
            b = pend.pop_front();
            if (b.last) begin
                nfr--;
                m_out++;
            end
        end
        if (do_commit) begin
            foreach (part[i]) begin
                b = part[i];
                b.ccyc = cyc;
                pend.push_back(b);
            end
            part.delete();
            nfr++;
            m_in++;
        end
        cyc++;
    endtask

    // one clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic step();
        bit    exp_v;
        beat_t f;
        if (rand_rdy) m_axis_tx.tready = ($urandom_range(0, 3) != 0);
        @(negedge clk156);
        exp_v = (pend.size() > 0) && (pend[0].ccyc <= cyc - 2);
        check("tvalid", 64'(m_axis_tx.tvalid), 64'(exp_v));
        if (exp_v) begin
            f = pend[0];
            check("tdata", m_axis_tx.tdata, f.data);
            check("tkeep", 64'(m_axis_tx.tkeep), 64'(f.keep));
            check("tlast", 64'(m_axis_tx.tlast), 64'(f.last));
        end
        check("frames_stored", 64'(frames_stored), 64'(nfr));
        check("s_tready", 64'(s_axis.tready), 64'(!reset));
        if (after_rst) begin
            check("rst_tdata", m_axis_tx.tdata, 64'h0);
            check("rst_tkeep", 64'(m_axis_tx.tkeep), 64'h0);
            check("rst_tlast", 64'(m_axis_tx.tlast), 64'h0);
        end
        @(posedge clk156);
        model_edge(exp_v && m_axis_tx.tready);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tuser  = u;
        step();
        s_axis.tvalid = 1'b0;
        s_axis.tuser  = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] lastkeep, input int bad_beat);
        for (int i = 0; i < len; i++)
            beat({$urandom, $urandom}, (i == len - 1) ? lastkeep : 8'hFF, i == len - 1, i == bad_beat);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        rand_rdy = 0;
        m_axis_tx.tready = 1'b1;
        for (int i = 0; i < 200 && pend.size() > 0; i++) step();
        idle(2);
    endtask

    task automatic check_stats(input string tag);
`ifdef ETH_TX_FIFO_STATS_EN
        check({tag, "_frames_in"}, 64'(frames_in), 64'(m_in));
        check({tag, "_frames_out"}, 64'(frames_out), 64'(m_out));
        check({tag, "_frames_dropped"}, 64'(frames_dropped), 64'(m_drop));
`else
        tests = tests + 0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0; fails = 0; cyc = 0; rand_rdy = 0;
        model_clear();
        reset = 1'b1;
        s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0;
        s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
        m_axis_tx.tready = 1'b0;
        repeat (3) @(posedge clk156);
        #1;
        after_rst = 1;
        reset = 1'b0;

        // reset state
        check("reset_tvalid", 64'(m_axis_tx.tvalid), 64'h0);
        check("reset_stored", 64'(frames_stored), 64'h0);
        check("tuser_out", 64'(m_axis_tx.tuser), 64'h0);

        // single 60-byte frame, exact 2-cycle latency
        m_axis_tx.tready = 1'b1;
        send_frame(8, 8'h0F, -1);
        check("t1_lat_plus1", 64'(m_axis_tx.tvalid), 64'h0);
        check("t1_stored", 64'(frames_stored), 64'h1);
        step();
        check("t1_lat_plus2", 64'(m_axis_tx.tvalid), 64'h1);
        drain();
        check("t1_stored_end", 64'(frames_stored), 64'h0);

        // output stall of 20 cycles in mid-frame
        send_frame(10, 8'h3F, -1);
        idle(3);
        m_axis_tx.tready = 1'b0;
        idle(20);
        drain();

        // overflow of the 15-word buffer while the MAC is stalled
        m_axis_tx.tready = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(8, 8'hFF, -1);
        idle(2);
        check("t3_stored", 64'(frames_stored), 64'h1);
        check_stats("t3");
        drain();

        // bad frame in the middle of three
        m_axis_tx.tready = 1'b1;
        send_frame(4, 8'h01, -1);
        send_frame(4, 8'h03, 2);
        send_frame(4, 8'h07, -1);
        drain();
        check_stats("t4");

        // stored-frame limit
        m_axis_tx.tready = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(1, 8'hFF, -1);
        idle(2);
        check("t5_stored", 64'(frames_stored), 64'h3);
        drain();

        // reset on the 4th beat of an outgoing frame
        m_axis_tx.tready = 1'b1;
        send_frame(8, 8'hFF, -1);
        idle(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_tvalid", 64'(m_axis_tx.tvalid), 64'h0);
        check("t6_stored", 64'(frames_stored), 64'h0);
        check_stats("t6");
        send_frame(5, 8'h1F, -1);
        drain();

        // randomized frames, gaps, bad frames and back-pressure
        rand_rdy = 1;
        for (int f = 0; f < 60; f++) begin
            send_frame($urandom_range(1, 10), 8'($urandom_range(1, 255)),
                       ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
        end
        drain();
        check_stats("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
